// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the stopwatch: FSM states, digit width, 7-segment decode.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam int DIGIT_W    = 4;
    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Segments ordered {g,f,e,d,c,b,a}, active-low.
    function automatic logic [6:0] seg7(input logic [DIGIT_W-1:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button debouncer: 2-FF synchronizer plus tick-counted stability filter,
// emitting a one-clock pulse on a debounced press (stable 1->0).
module btn_debounce #(
    parameter int DEB_MS = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic btn_n,
    output logic press
);

    localparam int CNT_W = $clog2(DEB_MS);

    logic [1:0]       sync_reg;
    logic             stable_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             press_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg   <= 2'b11;
            stable_reg <= 1'b1;
            cnt_reg    <= '0;
            press_reg  <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[0], btn_n};
            press_reg <= 1'b0;
            if (sync_reg[1] == stable_reg) begin
                cnt_reg <= '0;
            end else if (tick) begin
                if (cnt_reg == CNT_W'(DEB_MS - 1)) begin
                    stable_reg <= sync_reg[1];
                    cnt_reg    <= '0;
                    // Level is flipping; a press only when it was released before.
                    press_reg  <= stable_reg;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end
    end

    assign press = press_reg;

endmodule

// File: rtl/stopwatch_7seg.sv
// Stopwatch SS.hh on four 7-segment displays with start/stop/clear buttons.
// Optional lap-hold display when STOPWATCH_LAP_EN is defined.
module stopwatch_7seg
    import stopwatch_pkg::*;
#(
    parameter int DEB_MS         = 16,
    parameter int TICKS_PER_UNIT = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1k,
    input  logic       btn_start_n,
    input  logic       btn_clear_n,
`ifdef STOPWATCH_LAP_EN
    input  logic       btn_lap_n,
`endif
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic [6:0] hex2,
    output logic [6:0] hex3,
    output logic       hex2_dp,
    output logic       running
);

    localparam int SUB_W = $clog2(TICKS_PER_UNIT);

    state_t                                  state_reg;
    logic                                    running_reg;
    logic [SUB_W-1:0]                        sub_reg;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0]      digits_reg;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0]      digits_inc;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0]      disp_digits;
    logic                                    carry;
    logic                                    start_press;
    logic                                    clear_press;

    btn_debounce #(.DEB_MS(DEB_MS)) u_deb_start (
        .clk(clk), .rst_n(rst_n), .tick(tick_1k), .btn_n(btn_start_n), .press(start_press)
    );

    btn_debounce #(.DEB_MS(DEB_MS)) u_deb_clear (
        .clk(clk), .rst_n(rst_n), .tick(tick_1k), .btn_n(btn_clear_n), .press(clear_press)
    );

    // Ripple BCD increment; 99.99 rolls over to 00.00.
    always_comb begin
        digits_inc = digits_reg;
        carry      = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (carry) begin
                if (digits_reg[i] == DIGIT_W'(9)) begin
                    digits_inc[i] = '0;
                end else begin
                    digits_inc[i] = digits_reg[i] + 1'b1;
                    carry         = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            running_reg <= 1'b0;
            sub_reg     <= '0;
            digits_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start_press) begin
                        state_reg   <= RUN;
                        running_reg <= 1'b1;
                        sub_reg     <= '0;
                    end
                end
                RUN: begin
                    // A tick coinciding with the stop press is dropped.
                    if (start_press) begin
                        state_reg   <= PAUSE;
                        running_reg <= 1'b0;
                    end else if (tick_1k) begin
                        if (sub_reg == SUB_W'(TICKS_PER_UNIT - 1)) begin
                            sub_reg    <= '0;
                            digits_reg <= digits_inc;
                        end else begin
                            sub_reg <= sub_reg + 1'b1;
                        end
                    end
                end
                PAUSE: begin
                    if (clear_press) begin
                        state_reg   <= IDLE;
                        running_reg <= 1'b0;
                        sub_reg     <= '0;
                        digits_reg  <= '0;
                    end else if (start_press) begin
                        state_reg   <= RUN;
                        running_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    running_reg <= 1'b0;
                end
            endcase
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic                               lap_press;
    logic                               hold_reg;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0] lap_digits_reg;

    btn_debounce #(.DEB_MS(DEB_MS)) u_deb_lap (
        .clk(clk), .rst_n(rst_n), .tick(tick_1k), .btn_n(btn_lap_n), .press(lap_press)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_reg       <= 1'b0;
            lap_digits_reg <= '0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (lap_press) begin
                        hold_reg <= !hold_reg;
                        if (!hold_reg) begin
                            lap_digits_reg <= digits_reg;
                        end
                    end
                end
                PAUSE: begin
                    if (clear_press || lap_press) begin
                        hold_reg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign disp_digits = hold_reg ? lap_digits_reg : digits_reg;
`else
    assign disp_digits = digits_reg;
`endif

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_seg
        logic [6:0] seg_reg;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                seg_reg <= seg7('0);
            end else begin
                seg_reg <= seg7(disp_digits[gi]);
            end
        end
    end

    assign hex0    = g_seg[0].seg_reg;
    assign hex1    = g_seg[1].seg_reg;
    assign hex2    = g_seg[2].seg_reg;
    assign hex3    = g_seg[3].seg_reg;
    assign hex2_dp = 1'b0;
    assign running = running_reg;

endmodule

// File: tb/tb_stopwatch_7seg.sv
// Directed-vector bench for stopwatch_7seg (DEB_MS=2, TICKS_PER_UNIT=2, tick every 4 clk).
// Define STOPWATCH_LAP_EN for both DUT and bench to exercise the lap-hold feature.
module tb_stopwatch_7seg;

    typedef enum {OP_TICKS, OP_START, OP_CLEAR, OP_BOTH, OP_LAP} op_t;

    typedef struct {
        op_t         op;
        int          arg;
        logic [15:0] exp_bcd;
        logic        exp_run;
    } step_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_1k = 1'b0;
    logic       btn_start_n = 1'b1;
    logic       btn_clear_n = 1'b1;
`ifdef STOPWATCH_LAP_EN
    logic       btn_lap_n = 1'b1;
`endif
    logic [6:0] hex0, hex1, hex2, hex3;
    logic       hex2_dp;
    logic       running;

    int n_tests = 0;
    int n_fail  = 0;
    int tick_period = 4;
    int tcnt = 0;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    stopwatch_7seg #(.DEB_MS(2), .TICKS_PER_UNIT(2)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .tick_1k(tick_1k),
        .btn_start_n(btn_start_n),
        .btn_clear_n(btn_clear_n),
`ifdef STOPWATCH_LAP_EN
        .btn_lap_n(btn_lap_n),
`endif
        .hex0(hex0),
        .hex1(hex1),
        .hex2(hex2),
        .hex3(hex3),
        .hex2_dp(hex2_dp),
        .running(running)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        tcnt    = (tcnt + 1) % tick_period;
        tick_1k = (tcnt == 0);
    end

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (!tick_1k) @(posedge clk);
        end
    endtask

    // Holds the buttons through two ticks (debounce), releases, then lets the
    // release settle over two more ticks; ends 1.5 clk after a tick.
    task automatic do_press(input logic s, input logic c, input logic l);
        btn_start_n = !s;
        btn_clear_n = !c;
`ifdef STOPWATCH_LAP_EN
        btn_lap_n   = !l;
`endif
        wait_ticks(2);
        @(negedge clk);
        btn_start_n = 1'b1;
        btn_clear_n = 1'b1;
`ifdef STOPWATCH_LAP_EN
        btn_lap_n   = 1'b1;
`endif
        wait_ticks(2);
        repeat (2) @(negedge clk);
    endtask

    task automatic apply(input op_t op, input int arg);
        case (op)
            OP_TICKS: begin
                wait_ticks(arg);
                repeat (2) @(negedge clk);
            end
            OP_START: do_press(1'b1, 1'b0, 1'b0);
            OP_CLEAR: do_press(1'b0, 1'b1, 1'b0);
            OP_BOTH:  do_press(1'b1, 1'b1, 1'b0);
            OP_LAP:   do_press(1'b0, 1'b0, 1'b1);
            default:  ;
        endcase
    endtask

    task automatic check(input string name, input logic [15:0] exp_bcd, input logic exp_run);
        logic [27:0] exp_seg;
        logic [27:0] got_seg;
        exp_seg = {seg_tab[exp_bcd[15:12]], seg_tab[exp_bcd[11:8]],
                   seg_tab[exp_bcd[7:4]], seg_tab[exp_bcd[3:0]]};
        got_seg = {hex3, hex2, hex1, hex0};
        n_tests++;
        if (got_seg !== exp_seg) begin
            n_fail++;
            $display("FAIL %s display: got %b_%b_%b_%b, expected %b_%b_%b_%b (%h.%h)", name,
                     hex3, hex2, hex1, hex0, exp_seg[27:21], exp_seg[20:14], exp_seg[13:7],
                     exp_seg[6:0], exp_bcd[15:8], exp_bcd[7:0]);
        end
        n_tests++;
        if (running !== exp_run) begin
            n_fail++;
            $display("FAIL %s running: got %b, expected %b", name, running, exp_run);
        end
        $display("[TB] %s: expect %h.%h running=%b, got running=%b", name,
                 exp_bcd[15:8], exp_bcd[7:0], exp_run, running);
    endtask

    step_t steps[20];
`ifdef STOPWATCH_LAP_EN
    step_t lap_steps[10];
`endif

    initial begin
        steps[0]  = '{OP_CLEAR, 0,  16'h0000, 1'b0};  // clear in IDLE: no-op
        steps[1]  = '{OP_START, 0,  16'h0001, 1'b1};
        steps[2]  = '{OP_TICKS, 48, 16'h0025, 1'b1};  // 50 ticks since start
        steps[3]  = '{OP_CLEAR, 0,  16'h0027, 1'b1};  // clear ignored in RUN
        steps[4]  = '{OP_START, 0,  16'h0028, 1'b0};  // pause
        steps[5]  = '{OP_START, 0,  16'h0029, 1'b1};  // resume
        steps[6]  = '{OP_TICKS, 1,  16'h0029, 1'b1};  // sub = 1
        steps[7]  = '{OP_START, 0,  16'h0030, 1'b0};  // paused with sub = 1
        steps[8]  = '{OP_START, 0,  16'h0031, 1'b1};
        steps[9]  = '{OP_TICKS, 1,  16'h0032, 1'b1};  // only holds if sub was retained
        steps[10] = '{OP_BOTH,  0,  16'h0033, 1'b0};  // RUN: start wins
        steps[11] = '{OP_BOTH,  0,  16'h0000, 1'b0};  // PAUSE: clear wins
        steps[12] = '{OP_START, 0,  16'h0001, 1'b1};
        steps[13] = '{OP_TICKS, 1,  16'h0001, 1'b1};
        steps[14] = '{OP_START, 0,  16'h0002, 1'b0};
        steps[15] = '{OP_CLEAR, 0,  16'h0000, 1'b0};
        steps[16] = '{OP_START, 0,  16'h0001, 1'b1};
        steps[17] = '{OP_TICKS, 13, 16'h0007, 1'b1};
        steps[18] = '{OP_START, 0,  16'h0008, 1'b0};
        steps[19] = '{OP_CLEAR, 0,  16'h0000, 1'b0};
`ifdef STOPWATCH_LAP_EN
        lap_steps[0] = '{OP_START, 0,  16'h0001, 1'b1};
        lap_steps[1] = '{OP_TICKS, 22, 16'h0012, 1'b1};
        lap_steps[2] = '{OP_LAP,   0,  16'h0013, 1'b1};  // captured at press
        lap_steps[3] = '{OP_TICKS, 60, 16'h0013, 1'b1};  // held while counting
        lap_steps[4] = '{OP_LAP,   0,  16'h0046, 1'b1};  // release: live digits
        lap_steps[5] = '{OP_LAP,   0,  16'h0047, 1'b1};
        lap_steps[6] = '{OP_START, 0,  16'h0047, 1'b0};  // pause keeps hold
        lap_steps[7] = '{OP_LAP,   0,  16'h0049, 1'b0};  // lap in PAUSE drops hold
        lap_steps[8] = '{OP_CLEAR, 0,  16'h0000, 1'b0};
        lap_steps[9] = '{OP_LAP,   0,  16'h0000, 1'b0};  // ignored in IDLE
`endif

        // Reset state
        repeat (3) @(negedge clk);
        check("reset", 16'h0000, 1'b0);
        n_tests++;
        if (hex2_dp !== 1'b0) begin
            n_fail++;
            $display("FAIL reset dp: got %b, expected 0", hex2_dp);
        end
        rst_n = 1'b1;
        wait_ticks(1);
        repeat (2) @(negedge clk);

        // Glitch shorter than the debounce window
        btn_start_n = 1'b0;
        wait_ticks(1);
        @(negedge clk);
        btn_start_n = 1'b1;
        wait_ticks(3);
        repeat (2) @(negedge clk);
        check("glitch", 16'h0000, 1'b0);

        for (int i = 0; i < 20; i++) begin
            apply(steps[i].op, steps[i].arg);
            check($sformatf("step%0d", i), steps[i].exp_bcd, steps[i].exp_run);
        end

        // Asynchronous reset in the middle of a run
        apply(OP_START, 0);
        apply(OP_TICKS, 5);
        check("pre_reset", 16'h0003, 1'b1);
        rst_n = 1'b0;
        #1;
        check("async_reset", 16'h0000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        apply(OP_TICKS, 4);
        check("idle_after_reset", 16'h0000, 1'b0);

        // Run up to 99.99 with faster ticks, then wrap
        apply(OP_START, 0);
        check("wrap_start", 16'h0001, 1'b1);
        tick_period = 2;
        apply(OP_TICKS, 19996);
        check("full_scale", 16'h9999, 1'b1);
        apply(OP_TICKS, 2);
        check("wrap", 16'h0000, 1'b1);
        tick_period = 4;
        apply(OP_TICKS, 1);

`ifdef STOPWATCH_LAP_EN
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        apply(OP_TICKS, 1);
        for (int i = 0; i < 10; i++) begin
            apply(lap_steps[i].op, lap_steps[i].arg);
            check($sformatf("lap%0d", i), lap_steps[i].exp_bcd, lap_steps[i].exp_run);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
